mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data bus width in bits; legal values are 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have parameter MISALIGN_EN, default 1, meaning 1 = split misaligned accesses into two beats and 0 = flag them as errors.
REQ-004 SHALL use one clock and a synchronous, active-low reset: i_clk  in  1  clock (rising edge); i_rstn  in  1  synchronous active-low reset.
REQ-005 SHALL have core request ports: i_req_valid in 1; o_req_ready out 1; i_req_wen in 1 (1 = store, 0 = load); i_req_func3 in 3 (RISC-V funct3); i_req_addr in ADDR_W; i_req_wdata in DATA_W.
REQ-006 SHALL have core response ports: o_rsp_valid out 1 (one-cycle pulse); o_rsp_data out DATA_W (extended load data); o_rsp_err out 1.
REQ-007 SHALL have memory bus ports: o_mem_req out 1; i_mem_gnt in 1; o_mem_we out 1; o_mem_addr out ADDR_W (aligned to DATA_W/8); o_mem_be out DATA_W/8; o_mem_wdata out DATA_W; i_mem_rvalid in 1; i_mem_rdata in DATA_W.

Function
REQ-008 SHALL accept a request when i_req_valid and o_req_ready are both high; o_req_ready SHALL be high only in IDLE; at most one access SHALL be outstanding.
REQ-009 SHALL derive NB = DATA_W/8, OFF = addr[log2(NB)-1:0] and SIZE = 1 << func3[1:0] bytes; func3[2] = 1 SHALL mean zero-extend.
REQ-010 SHALL flag func3 as illegal for: 3 when DATA_W = 32; 6 or 7; 4, 5 or 7 on stores; 6 when DATA_W = 32.
REQ-011 SHALL treat an access as crossing when OFF + SIZE > NB; with MISALIGN_EN = 0, a crossing access SHALL be an error.
REQ-012 SHALL handle an error request as follows: no bus activity; o_rsp_valid = 1, o_rsp_err = 1, o_rsp_data = 0 in the cycle after acceptance.
REQ-013 SHALL implement FSM states IDLE -> REQ0 -> WAIT0 -> [REQ1 -> WAIT1] -> RESP -> IDLE; error requests SHALL go IDLE -> RESP.
REQ-014 SHALL hold o_mem_req high in REQ0/REQ1 until i_mem_gnt; the address, byte enables, write data and o_mem_we SHALL remain stable while o_mem_req is high and ungranted.
REQ-015 SHALL drive beat 0 as: addr = aligned(addr); be = ((1<<SIZE)-1) << OFF, truncated to NB bits; wdata = wdata << 8*OFF.
REQ-016 SHALL drive beat 1 (crossing only) as: addr = aligned(addr) + NB, wrapping modulo 2^ADDR_W; be = ((1<<SIZE)-1) >> (NB-OFF); wdata = wdata >> 8*(NB-OFF).
REQ-017 SHALL complete a store beat on grant, skipping WAIT; the store response SHALL come in the cycle after the final grant.
REQ-018 SHALL complete a load beat on i_mem_rvalid in WAIT; i_mem_rvalid outside WAIT0/WAIT1 SHALL be ignored.
REQ-019 SHALL assemble load data as (rdata0 >> 8*OFF) | (rdata1 << 8*(NB-OFF)), masked to SIZE bytes, then sign- or zero-extended to DATA_W.
REQ-020 SHALL present o_rsp_valid for exactly one cycle, in RESP, with no backpressure; o_rsp_data SHALL be 0 for stores.
REQ-021 SHALL have a minimum aligned-load latency of 3 cycles from acceptance to o_rsp_valid, given gnt on first request and rvalid the next cycle.
REQ-022 SHALL NOT generate a second bus beat for a request with SIZE = NB and OFF = 0.

Reset
REQ-023 SHALL, when i_rstn = 0 at a rising edge, set state = IDLE and set o_req_ready = 1 after reset, with o_rsp_valid, o_rsp_err, o_mem_req and o_mem_we = 0 and o_rsp_data, o_mem_addr, o_mem_be and o_mem_wdata = 0.
REQ-024 SHALL abandon any in-flight access on reset mid-operation and issue no response for it.

Structure
REQ-025 SHALL place in a shared package lsu_pkg: funct3 encodings (LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD), the FSM state enum, and a size-to-mask function.
REQ-026 SHALL use one sub-module, lsu_align, which is combinational and covers byte-enable/wdata shifting and load merge/extension.

Verification (DATA_W = 32)
REQ-027 SHALL cover: SW at 0x100, wdata 0xDEADBEEF -> one beat, addr 0x100, be 1111, wdata 0xDEADBEEF; response err = 0.
REQ-028 SHALL cover: LB at 0x103, rdata 0x80FF0000 -> o_rsp_data 0xFFFFFF80; the same access with LBU -> 0x00000080.
REQ-029 SHALL cover: LHU at 0x103, MISALIGN_EN = 1 -> beat 0 addr 0x100 be 1000 with rdata 0xAB000000, beat 1 addr 0x104 be 0001 with rdata 0x000000CD -> o_rsp_data 0x0000CDAB.
REQ-030 SHALL cover: SW at 0x102, wdata 0x11223344 -> beat 0 be 1100 wdata 0x33440000; beat 1 addr 0x104 be 0011 wdata 0x00001122.
REQ-031 SHALL cover: MISALIGN_EN = 0, LW at 0x101 -> o_mem_req never high; o_rsp_valid = 1, o_rsp_err = 1 one cycle later.
REQ-032 SHALL cover: i_rstn low during WAIT1 -> next cycle IDLE, o_req_ready = 1, no o_rsp_valid, and a late i_mem_rvalid is ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared load/store-unit definitions: funct3 encodings, FSM states and the
// access-size to byte-mask helper.
package lsu_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LD  = 3'b011;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] LWU = 3'b110;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;
   localparam logic [2:0] SD  = 3'b011;

   typedef enum logic [2:0] {
      IDLE,
      REQ0,
      WAIT0,
      REQ1,
      WAIT1,
      RESP
   } lsu_state_e;

   // One bit per byte of the access, LSB aligned.
   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'd0:    size_mask = 8'h01;
         2'd1:    size_mask = 8'h03;
         2'd2:    size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and store data for both beats,
// and merge plus sign/zero extension of load data.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [$clog2(DATA_W/8)-1:0] off,
   input  logic [1:0]                  sz,
   input  logic                        zext,
   input  logic [DATA_W-1:0]           wdata,
   input  logic [DATA_W-1:0]           rdata0,
   input  logic [DATA_W-1:0]           rdata1,
   output logic [DATA_W/8-1:0]         be0,
   output logic [DATA_W/8-1:0]         be1,
   output logic [DATA_W-1:0]           wdata0,
   output logic [DATA_W-1:0]           wdata1,
   output logic [DATA_W-1:0]           ldata
);

   localparam int NB = DATA_W / 8;

   logic [NB-1:0]       mask;
   logic [2*NB-1:0]     be_full;
   logic [2*DATA_W-1:0] w_full;
   logic [DATA_W-1:0]   merged;
   logic                sbit;
   logic                fill;

   // Shifting the double-width word splits it into the beat-0 and beat-1 halves.
   assign mask    = NB'(size_mask(sz));
   assign be_full = {{NB{1'b0}}, mask} << off;
   assign be0     = be_full[NB-1:0];
   assign be1     = be_full[2*NB-1:NB];
   assign w_full  = {{DATA_W{1'b0}}, wdata} << {off, 3'b000};
   assign wdata0  = w_full[DATA_W-1:0];
   assign wdata1  = w_full[2*DATA_W-1:DATA_W];
   assign merged  = DATA_W'({rdata1, rdata0} >> {off, 3'b000});

   always_comb begin
      case (sz)
         2'd0:    sbit = merged[7];
         2'd1:    sbit = merged[15];
         2'd2:    sbit = merged[31];
         default: sbit = merged[DATA_W-1];
      endcase
   end

   assign fill = sbit & ~zext;

   for (genvar b = 0; b < NB; b++) begin : g_ext
      assign ldata[8*b +: 8] = mask[b] ? merged[8*b +: 8] : {8{fill}};
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one outstanding access, misaligned accesses split into two
// bus beats (or rejected), load data merged and extended.
module mem_access_unit
   import lsu_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int MISALIGN_EN = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_wen,
   input  logic [2:0]            i_req_func3,
   input  logic [ADDR_W-1:0]     i_req_addr,
   input  logic [DATA_W-1:0]     i_req_wdata,
   output logic                  o_rsp_valid,
   output logic [DATA_W-1:0]     o_rsp_data,
   output logic                  o_rsp_err,
   output logic                  o_mem_req,
   input  logic                  i_mem_gnt,
   output logic                  o_mem_we,
   output logic [ADDR_W-1:0]     o_mem_addr,
   output logic [DATA_W/8-1:0]   o_mem_be,
   output logic [DATA_W-1:0]     o_mem_wdata,
   input  logic                  i_mem_rvalid,
   input  logic [DATA_W-1:0]     i_mem_rdata
);

   localparam int NB   = DATA_W / 8;
   localparam int OFFW = $clog2(NB);

   lsu_state_e        state, state_nx;
   logic              wen_q;
   logic [2:0]        f3_q;
   logic [OFFW-1:0]   off_q;
   logic [ADDR_W-1:0] base_q;
   logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q;
   logic              cross_q, err_q;

   logic [OFFW-1:0]   off_in;
   logic [4:0]        end_in;
   logic              cross_in, illegal, err_in, accept;

   logic [NB-1:0]     be0, be1;
   logic [DATA_W-1:0] wdata0, wdata1, ldata;

   assign off_in   = i_req_addr[OFFW-1:0];
   assign end_in   = 5'(off_in) + (5'd1 << i_req_func3[1:0]);
   assign cross_in = end_in > 5'(NB);
   assign illegal  = ((i_req_func3 == LD) && (DATA_W == 32))
                   || (i_req_func3[2:1] == 2'b11)
                   || (i_req_wen && i_req_func3[2]);
   assign err_in   = illegal || (cross_in && (MISALIGN_EN == 0));
   assign accept   = i_req_valid && (state == IDLE);

   always_ff @(posedge i_clk) begin
      if (!i_rstn) state <= IDLE;
      else         state <= state_nx;
   end

   // Request context and returned read beats; qualified by state, so no reset needed.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         wen_q    <= i_req_wen;
         f3_q     <= i_req_func3;
         off_q    <= off_in;
         base_q   <= {i_req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
         wdata_q  <= i_req_wdata;
         cross_q  <= cross_in;
         err_q    <= err_in;
         rdata1_q <= '0;
      end
      if (state == WAIT0 && i_mem_rvalid) rdata0_q <= i_mem_rdata;
      if (state == WAIT1 && i_mem_rvalid) rdata1_q <= i_mem_rdata;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (i_req_valid) state_nx = err_in ? RESP : REQ0;
         REQ0:    if (i_mem_gnt)   state_nx = !wen_q ? WAIT0 : (cross_q ? REQ1 : RESP);
         WAIT0:   if (i_mem_rvalid) state_nx = cross_q ? REQ1 : RESP;
         REQ1:    if (i_mem_gnt)   state_nx = wen_q ? RESP : WAIT1;
         WAIT1:   if (i_mem_rvalid) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      o_req_ready = (state == IDLE);
      o_mem_req   = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_be    = '0;
      o_mem_wdata = '0;
      o_rsp_valid = 1'b0;
      o_rsp_err   = 1'b0;
      o_rsp_data  = '0;
      if (state == REQ0) begin
         o_mem_req   = 1'b1;
         o_mem_we    = wen_q;
         o_mem_addr  = base_q;
         o_mem_be    = be0;
         o_mem_wdata = wdata0;
      end else if (state == REQ1) begin
         o_mem_req   = 1'b1;
         o_mem_we    = wen_q;
         o_mem_addr  = base_q + ADDR_W'(NB);
         o_mem_be    = be1;
         o_mem_wdata = wdata1;
      end
      if (state == RESP) begin
         o_rsp_valid = 1'b1;
         o_rsp_err   = err_q;
         if (!err_q && !wen_q) o_rsp_data = ldata;
      end
   end

   lsu_align #(.DATA_W(DATA_W)) u_align (
      .off    (off_q),
      .sz     (f3_q[1:0]),
      .zext   (f3_q[2]),
      .wdata  (wdata_q),
      .rdata0 (rdata0_q),
      .rdata1 (rdata1_q),
      .be0    (be0),
      .be1    (be1),
      .wdata0 (wdata0),
      .wdata1 (wdata1),
      .ldata  (ldata)
   );

endmodule
